// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the HI/LO divide sequencer.
package mips_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } div_state_t;

  localparam logic [5:0] FUNCT_DIVU = 6'd27;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Handshake between EX/ID control and the HI/LO divide sequencer.
interface hilo_div_ctrl_if #(parameter int WIDTH = 32);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             abort;
  logic             mf_req;
  logic             mf_sel;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hilo_rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dividend, divisor, abort, mf_req, mf_sel,
    input  stall, busy, done, hilo_rdata, hi, lo
  );

  modport slave (
    input  start, dividend, divisor, abort, mf_req, mf_sel,
    output stall, busy, done, hilo_rdata, hi, lo
  );

endinterface

// File: rtl/hilo_div_ctrl_div_step.sv
// One restoring-division step: shift {rem,quo} left, subtract divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] shifted_s;
  logic           ge_s;

  // compare on WIDTH+1 bits; the difference always fits WIDTH bits since rem < divisor
  always_comb begin
    shifted_s = {rem, quo[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, divisor});
    if (ge_s) begin
      next_rem = shifted_s[WIDTH-1:0] - divisor;
    end else begin
      next_rem = shifted_s[WIDTH-1:0];
    end
    next_quo = {quo[WIDTH-2:0], ge_s};
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// DIVU sequencer owning HI/LO: one quotient bit per cycle, stalls dependent MF reads and a second DIVU.
module hilo_div_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  hilo_div_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  div_state_t       state_r, state_s;
  logic [CW-1:0]    count_r, count_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] quo_r, quo_s;
  logic [WIDTH-1:0] dvs_r, dvs_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvs_r),
    .next_rem (step_rem_s),
    .next_quo (step_quo_s)
  );

  // state, datapath and architectural HI/LO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      rem_r   <= rem_s;
      quo_r   <= quo_s;
      dvs_r   <= dvs_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      done_r  <= done_s;
    end
  end

  // next state; abort always beats both acceptance and completion
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    rem_s   = rem_r;
    quo_s   = quo_r;
    dvs_s   = dvs_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.divisor != {WIDTH{1'b0}}) begin
            dvs_s   = bus.divisor;
            rem_s   = {WIDTH{1'b0}};
            quo_s   = bus.dividend;
            count_s = {CW{1'b0}};
            state_s = CALC;
          end else begin
            hi_s   = bus.dividend;
            lo_s   = {WIDTH{1'b1}};
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_s = IDLE;
        end else begin
          rem_s   = step_rem_s;
          quo_s   = step_quo_s;
          count_s = count_r + CW'(1);
          if (count_r == LAST_COUNT) begin
            hi_s    = step_rem_s;
            lo_s    = step_quo_s;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = CALC;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_r == CALC);
  assign bus.stall      = bus.busy & (bus.mf_req | bus.start);
  assign bus.done       = done_r;
  assign bus.hi         = hi_r;
  assign bus.lo         = lo_r;
  assign bus.hilo_rdata = bus.mf_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: timing of busy/done/stall, divide by zero, abort and reset.
module tb_hilo_div_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  hilo_div_ctrl_if #(.WIDTH(32)) bus ();

  hilo_div_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 2 time units after each rising edge
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    next_cycle();
    bus.start    = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    bus.abort    = 1'b0;
    bus.mf_req   = 1'b0;
    bus.mf_sel   = 1'b0;
    next_cycle();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // 100 / 7: busy cycles 1..32, done only in 33
    issue(32'd100, 32'd7);
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("t1_busy_c%0d", c), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("t1_done_c%0d", c), {31'd0, bus.done}, 32'd0);
      next_cycle();
    end
    chk("t1_busy33", {31'd0, bus.busy}, 32'd0);
    chk("t1_done33", {31'd0, bus.done}, 32'd1);
    chk("t1_hi", bus.hi, 32'd2);
    chk("t1_lo", bus.lo, 32'd14);
    next_cycle();
    chk("t1_done34", {31'd0, bus.done}, 32'd0);

    // idle MF read never stalls
    bus.mf_req = 1'b1;
    bus.mf_sel = 1'b0;
    #1;
    chk("idle_mf_stall", {31'd0, bus.stall}, 32'd0);
    chk("idle_mf_rdata", bus.hilo_rdata, 32'd14);
    bus.mf_req = 1'b0;
    next_cycle();

    // 0xFFFFFFFF / 1 then 5 / 0 issued in the completion cycle
    issue(32'hFFFF_FFFF, 32'd1);
    for (int c = 1; c <= 32; c++) next_cycle();
    chk("t2_lo", bus.lo, 32'hFFFF_FFFF);
    chk("t2_hi", bus.hi, 32'd0);
    chk("t2_done33", {31'd0, bus.done}, 32'd1);
    issue(32'd5, 32'd0);
    chk("t2z_hi", bus.hi, 32'd5);
    chk("t2z_lo", bus.lo, 32'hFFFF_FFFF);
    chk("t2z_done", {31'd0, bus.done}, 32'd1);
    chk("t2z_busy", {31'd0, bus.busy}, 32'd0);
    next_cycle();
    chk("t2z_done2", {31'd0, bus.done}, 32'd0);
    chk("t2z_busy2", {31'd0, bus.busy}, 32'd0);

    // MFHI from cycle 5 stalls until the result lands
    issue(32'd100, 32'd7);
    bus.mf_sel = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      bus.mf_req = (c >= 5) ? 1'b1 : 1'b0;
      #1;
      chk($sformatf("t3_stall_c%0d", c), {31'd0, bus.stall}, (c >= 5) ? 32'd1 : 32'd0);
      next_cycle();
    end
    chk("t3_stall33", {31'd0, bus.stall}, 32'd0);
    chk("t3_rdata_hi", bus.hilo_rdata, 32'd2);
    bus.mf_sel = 1'b0;
    #1;
    chk("t3_rdata_lo", bus.hilo_rdata, 32'd14);
    bus.mf_req = 1'b0;
    next_cycle();

    // second DIVU held from cycle 10, accepted in cycle 33, result in 66
    issue(32'd100, 32'd7);
    for (int c = 1; c <= 32; c++) begin
      if (c >= 10) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd9;
      end
      #1;
      chk($sformatf("t4_stall_c%0d", c), {31'd0, bus.stall}, (c >= 10) ? 32'd1 : 32'd0);
      next_cycle();
    end
    chk("t4_stall33", {31'd0, bus.stall}, 32'd0);
    chk("t4_done33", {31'd0, bus.done}, 32'd1);
    chk("t4_hi1", bus.hi, 32'd2);
    next_cycle();
    bus.start = 1'b0;
    chk("t4_busy34", {31'd0, bus.busy}, 32'd1);
    for (int c = 34; c <= 65; c++) next_cycle();
    chk("t4_done66", {31'd0, bus.done}, 32'd1);
    chk("t4_hi2", bus.hi, 32'd1);
    chk("t4_lo2", bus.lo, 32'd111);
    next_cycle();

    // abort mid-CALC keeps prior HI=3 / LO=4
    issue(32'd31, 32'd7);
    for (int c = 1; c <= 32; c++) next_cycle();
    chk("t5_pre_hi", bus.hi, 32'd3);
    chk("t5_pre_lo", bus.lo, 32'd4);
    next_cycle();
    issue(32'd100, 32'd7);
    for (int c = 1; c <= 9; c++) next_cycle();
    bus.abort = 1'b1;
    next_cycle();
    bus.abort = 1'b0;
    chk("t5_busy11", {31'd0, bus.busy}, 32'd0);
    chk("t5_done11", {31'd0, bus.done}, 32'd0);
    for (int c = 12; c <= 40; c++) begin
      chk($sformatf("t5_nodone_c%0d", c), {31'd0, bus.done}, 32'd0);
      next_cycle();
    end
    chk("t5_hi", bus.hi, 32'd3);
    chk("t5_lo", bus.lo, 32'd4);

    // abort together with start in IDLE: nothing accepted
    bus.abort = 1'b1;
    issue(32'd9, 32'd0);
    bus.abort = 1'b0;
    chk("t5b_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5b_done", {31'd0, bus.done}, 32'd0);
    chk("t5b_hi", bus.hi, 32'd3);

    // asynchronous reset mid-CALC, then a normal division
    issue(32'd100, 32'd7);
    for (int c = 1; c <= 14; c++) next_cycle();
    bus.mf_req = 1'b1;
    #1;
    chk("t6_stall_pre", {31'd0, bus.stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_stall", {31'd0, bus.stall}, 32'd0);
    chk("t6_done", {31'd0, bus.done}, 32'd0);
    chk("t6_hi", bus.hi, 32'd0);
    chk("t6_lo", bus.lo, 32'd0);
    bus.mf_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    issue(32'd100, 32'd7);
    for (int c = 1; c <= 32; c++) next_cycle();
    chk("t6_done33", {31'd0, bus.done}, 32'd1);
    chk("t6_hi_new", bus.hi, 32'd2);
    chk("t6_lo_new", bus.lo, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
